// File: rtl/audio_uart_pkg.sv
// Shared types and constants for the audio_uart serial transmitter.
// The optional parity bit is enabled by defining AUDIO_UART_PARITY_EN.
package audio_uart_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } state_t;

  localparam int unsigned DATA_BITS = 8;

  localparam logic IDLE_LEVEL  = 1'b1;
  localparam logic START_LEVEL = 1'b0;
  localparam logic STOP_LEVEL  = 1'b1;

endpackage

// File: rtl/audio_uart_baud_tick.sv
// Per-bit cycle counter for audio_uart: counts CLKS_PER_BIT cycles and
// flags the final and second-to-last cycle of each serial bit.
module audio_uart_baud_tick #(
  parameter int unsigned CLKS_PER_BIT = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic restart,
  output logic bit_done,
  output logic bit_almost
);

  localparam int unsigned CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CW-1:0] LAST   = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] ALMOST = CW'(CLKS_PER_BIT - 2);

  logic [CW-1:0] cnt;
  logic [CW-1:0] cnt_nxt;

  // Wrap to zero on every bit boundary or when the FSM holds us in restart.
  always_comb begin
    cnt_nxt = cnt + CW'(1);
    if (restart || (cnt == LAST)) begin
      cnt_nxt = '0;
    end
  end

  // Flags are registered one cycle ahead so they line up with cnt.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt        <= '0;
      bit_done   <= 1'b0;
      bit_almost <= 1'b0;
    end else begin
      cnt        <= cnt_nxt;
      bit_done   <= (cnt_nxt == LAST);
      bit_almost <= (cnt_nxt == ALMOST);
    end
  end

endmodule

// File: rtl/audio_uart.sv
// Byte-wide UART transmitter: valid/ready byte input, 8N1 serial output.
// Define AUDIO_UART_PARITY_EN to insert an even-parity bit before stop.
module audio_uart
  import audio_uart_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = 16
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  input  logic [DATA_BITS-1:0] i_data,
  input  logic                 i_valid,
  output logic                 o_ready,
  output logic                 o_serial
);

  state_t               state;
  logic [DATA_BITS-1:0] shreg;
  logic [2:0]           bit_idx;
  logic                 bit_done;
  logic                 bit_almost;
  logic                 accept_c;
  logic                 restart_c;
`ifdef AUDIO_UART_PARITY_EN
  logic                 parity_bit;
`endif

  assign accept_c  = i_valid && o_ready;
  assign restart_c = (state == IDLE);

  audio_uart_baud_tick #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_baud_tick (
    .clk       (i_clk),
    .rst       (i_rst),
    .restart   (restart_c),
    .bit_done  (bit_done),
    .bit_almost(bit_almost)
  );

  // o_ready is raised one cycle early so it is high exactly in the last STOP cycle.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state    <= IDLE;
      shreg    <= '0;
      bit_idx  <= '0;
      o_serial <= IDLE_LEVEL;
      o_ready  <= 1'b0;
`ifdef AUDIO_UART_PARITY_EN
      parity_bit <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          o_serial <= IDLE_LEVEL;
          o_ready  <= 1'b1;
          if (accept_c) begin
            state    <= START;
            shreg    <= i_data;
            o_serial <= START_LEVEL;
            o_ready  <= 1'b0;
`ifdef AUDIO_UART_PARITY_EN
            parity_bit <= ^i_data;
`endif
          end
        end

        START: begin
          if (bit_done) begin
            state    <= DATA;
            bit_idx  <= '0;
            o_serial <= shreg[0];
            shreg    <= shreg >> 1;
          end
        end

        DATA: begin
          if (bit_done) begin
            if (bit_idx == 3'(DATA_BITS - 1)) begin
`ifdef AUDIO_UART_PARITY_EN
              state    <= PARITY;
              o_serial <= parity_bit;
`else
              state    <= STOP;
              o_serial <= STOP_LEVEL;
`endif
            end else begin
              bit_idx  <= bit_idx + 3'd1;
              o_serial <= shreg[0];
              shreg    <= shreg >> 1;
            end
          end
        end

`ifdef AUDIO_UART_PARITY_EN
        PARITY: begin
          if (bit_done) begin
            state    <= STOP;
            o_serial <= STOP_LEVEL;
          end
        end
`endif

        STOP: begin
          if (bit_almost) begin
            o_ready <= 1'b1;
          end
          if (bit_done) begin
            if (accept_c) begin
              // Back-to-back: next start bit follows the stop bit directly.
              state    <= START;
              shreg    <= i_data;
              o_serial <= START_LEVEL;
              o_ready  <= 1'b0;
`ifdef AUDIO_UART_PARITY_EN
              parity_bit <= ^i_data;
`endif
            end else begin
              state    <= IDLE;
              o_serial <= IDLE_LEVEL;
              o_ready  <= 1'b1;
            end
          end
        end

        default: begin
          state    <= IDLE;
          o_serial <= IDLE_LEVEL;
          o_ready  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_audio_uart.sv
// Scoreboard bench for audio_uart: accepted bytes are queued with their
// acceptance cycle, and a line monitor checks every cycle of every frame.
module tb_audio_uart;

  localparam int CPB = 4;
`ifdef AUDIO_UART_PARITY_EN
  localparam int FRAME_BITS = 11;
  localparam bit PAR        = 1'b1;
`else
  localparam int FRAME_BITS = 10;
  localparam bit PAR        = 1'b0;
`endif
  localparam int FL = FRAME_BITS * CPB;

  typedef struct {
    logic [7:0] data;
    int         acc;
  } exp_t;

  logic       i_clk;
  logic       i_rst;
  logic [7:0] i_data;
  logic       i_valid;
  logic       o_ready;
  logic       o_serial;

  exp_t       q[$];
  int         cyc      = 0;
  bit         rst_edge = 1'b1;
  int         tests    = 0;
  int         fails    = 0;
  bit         in_frame = 1'b0;
  int         pos      = 0;
  logic [7:0] cur      = '0;

  audio_uart #(
    .CLKS_PER_BIT(CPB)
  ) dut (
    .i_clk   (i_clk),
    .i_rst   (i_rst),
    .i_data  (i_data),
    .i_valid (i_valid),
    .o_ready (o_ready),
    .o_serial(o_serial)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference frame: start, 8 data bits LSB first, optional even parity, stop.
  function automatic logic exp_bit(input logic [7:0] d, input int b);
    if (b == 0) return 1'b0;
    if (b <= 8) return d[b-1];
    if (PAR && b == 9) return ^d;
    return 1'b1;
  endfunction

  // Handshake recorder: push on accept; reset discards anything pending.
  always @(posedge i_clk) begin
    if (i_rst) q.delete();
    else if (i_valid && o_ready) q.push_back('{data: i_data, acc: cyc});
    rst_edge = i_rst;
    cyc++;
  end

  // Line monitor: pops an expected byte at each start bit and checks the frame.
  always @(negedge i_clk) begin
    exp_t e;
    if (rst_edge) begin
      in_frame = 1'b0;
      chk("rst_serial", 32'(o_serial), 1);
      chk("rst_ready", 32'(o_ready), 0);
    end else begin
      if (!in_frame) begin
        if (o_serial === 1'b0) begin
          chk("pending_at_start", 32'(q.size() != 0), 1);
          if (q.size() != 0) begin
            e = q.pop_front();
            chk("start_latency", 32'(cyc - 1), 32'(e.acc));
            cur      = e.data;
            pos      = 0;
            in_frame = 1'b1;
          end
        end else if (q.size() != 0 && q[0].acc < cyc) begin
          chk("start_missing", 32'(o_serial), 0);
          void'(q.pop_front());
        end else begin
          chk("idle_ready", 32'(o_ready), 1);
        end
      end
      if (in_frame) begin
        chk("frame_bit", 32'(o_serial), 32'(exp_bit(cur, pos / CPB)));
        chk("busy_ready", 32'(o_ready), 32'(pos == FL - 1));
        pos++;
        if (pos == FL) in_frame = 1'b0;
      end
    end
  end

  task automatic idle(input int n);
    repeat (n) @(negedge i_clk);
  endtask

  // Present d until accepted; without keep, drop valid and scramble i_data afterwards.
  task automatic send(input logic [7:0] d, input bit keep);
    int n = 0;
    i_data  = d;
    i_valid = 1'b1;
    while (o_ready !== 1'b1 && n < 3 * FL) begin
      @(negedge i_clk);
      n++;
    end
    if (n >= 3 * FL) begin
      chk("ready_timeout", 32'(o_ready), 1);
      i_valid = 1'b0;
      return;
    end
    @(negedge i_clk);
    if (!keep) begin
      i_valid = 1'b0;
      i_data  = ~d;
    end
  endtask

  initial begin
    int n;
    i_rst   = 1'b1;
    i_valid = 1'b0;
    i_data  = '0;
    idle(3);
    i_rst = 1'b0;
    idle(2);

    send(8'hA5, 1'b0);
    idle(50);
    send(8'h00, 1'b1);
    send(8'hFF, 1'b0);
    idle(50);
    send(8'h3C, 1'b0);
    idle(100 + FL);
    send(8'hC3, 1'b0);
    idle(50);
    send(8'h55, 1'b0);
    idle(50);
    send(8'h07, 1'b0);
    idle(50);
    send(8'h03, 1'b0);
    idle(50);

    // Reset during data bit 3, then a clean frame.
    send(8'h5A, 1'b0);
    idle(17);
    i_rst = 1'b1;
    @(negedge i_clk);
    i_rst = 1'b0;
    idle(3);
    send(8'h81, 1'b0);
    idle(FL + 5);

    // Reset coinciding with a handshake: byte must not be taken.
    i_data  = 8'h99;
    i_valid = 1'b1;
    i_rst   = 1'b1;
    @(negedge i_clk);
    i_rst   = 1'b0;
    i_valid = 1'b0;
    idle(FL);

    for (int i = 0; i < 150; i++) begin
      bit keep;
      keep = ($urandom_range(0, 2) == 0);
      send(8'($urandom), keep);
      if (!keep) idle($urandom_range(0, 12));
    end
    i_valid = 1'b0;

    n = 0;
    while ((q.size() != 0 || in_frame) && n < 4 * FL) begin
      @(negedge i_clk);
      n++;
    end
    if (n >= 4 * FL) chk("drain", 32'(q.size()), 0);
    idle(2);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
